// File: rtl/bp_cfg_pkg.sv
// bp_cfg_pkg: shared types and constants for the runtime config register file.
package bp_cfg_pkg;
  typedef enum logic [3:0] {
    e_reg_freeze = 4'd0,
    e_reg_icache = 4'd1,
    e_reg_dcache = 4'd2,
    e_reg_cce    = 4'd3,
    e_reg_status = 4'd4
  } bp_cfg_reg_e;
  typedef enum logic [1:0] {e_cache_uncached, e_cache_normal, e_cache_nonspec} bp_cache_mode_e;
  typedef enum logic {e_cce_normal, e_cce_uncached} bp_cce_mode_e;
  typedef enum logic [1:0] {e_ready, e_wait, e_resp} bp_cfg_state_e;
  localparam logic [3:0] cfg_bcast_core_gp = 4'hF;
endpackage

// File: rtl/bp_cfg_core_regs.sv
// bp_cfg_core_regs: per-core freeze, cache-mode and CCE-mode registers.
module bp_cfg_core_regs
  import bp_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       we,
  input  logic [3:0] sel,
  input  logic [1:0] data,
  output logic       freeze,
  output logic [1:0] icache_mode,
  output logic [1:0] dcache_mode,
  output logic       cce_mode
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freeze      <= 1'b1;
      icache_mode <= 2'd0;
      dcache_mode <= 2'd0;
      cce_mode    <= 1'b0;
    end else begin
      freeze      <= (we && sel == e_reg_freeze) ? data[0] : freeze;
      icache_mode <= (we && sel == e_reg_icache) ? data : icache_mode;
      dcache_mode <= (we && sel == e_reg_dcache) ? data : dcache_mode;
      cce_mode    <= (we && sel == e_reg_cce) ? data[0] : cce_mode;
    end
  end
endmodule

// File: rtl/bp_cfg_regfile.sv
// bp_cfg_regfile: runtime per-core config register file with freeze handshake sequencing.
// Define BP_CFG_READBACK_EN to enable the read datapath; otherwise every read errors.
module bp_cfg_regfile
  import bp_cfg_pkg::*;
#(
  parameter int num_core_p       = 1,
  parameter int data_width_p     = 64,
  parameter int addr_width_p     = 8,
  parameter int freeze_timeout_p = 255
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      cfg_v_i,
  input  logic                      cfg_w_i,
  input  logic [addr_width_p-1:0]   cfg_addr_i,
  input  logic [data_width_p-1:0]   cfg_data_i,
  output logic                      cfg_ready_o,
  output logic                      resp_v_o,
  output logic [data_width_p-1:0]   resp_data_o,
  output logic                      resp_err_o,
  input  logic                      resp_yumi_i,
  input  logic [num_core_p-1:0]     core_frozen_i,
  output logic [num_core_p-1:0]     freeze_o,
  output logic [2*num_core_p-1:0]   icache_mode_o,
  output logic [2*num_core_p-1:0]   dcache_mode_o,
  output logic [num_core_p-1:0]     cce_mode_o
);
  localparam int cnt_w = freeze_timeout_p > 0 ? $clog2(freeze_timeout_p + 1) : 1;
  bp_cfg_state_e state;
  logic [cnt_w-1:0] cnt;
  logic [num_core_p-1:0] target, wait_mask, core_we;
  logic [3:0] core_idx, sel;
  logic [1:0] rdata;
  logic bcast, bad_core, bad_sel, err, freeze_up, accept, unused;
  assign core_idx  = cfg_addr_i[7:4];
  assign sel       = cfg_addr_i[3:0];
  assign bcast     = core_idx == cfg_bcast_core_gp;
  assign bad_core  = !bcast && int'(core_idx) >= num_core_p;
  assign bad_sel   = sel > e_reg_status;
  assign accept    = cfg_v_i && cfg_ready_o && state == e_ready;
  assign freeze_up = cfg_w_i && sel == e_reg_freeze && cfg_data_i[0] && |(target & ~freeze_o);
  assign core_we   = target & {num_core_p{accept && cfg_w_i && !err}};
  assign unused    = ^{cfg_data_i, cfg_addr_i};
  always_comb begin
    for (int c = 0; c < num_core_p; c++) target[c] = bcast || int'(core_idx) == c;
  end
`ifdef BP_CFG_READBACK_EN
  assign err = bad_core || bad_sel || (cfg_w_i ? sel == e_reg_status : bcast);
  always_comb begin
    rdata = 2'd0;
    for (int c = 0; c < num_core_p; c++)
      if (int'(core_idx) == c)
        rdata = sel == e_reg_freeze ? {1'b0, freeze_o[c]} :
                sel == e_reg_icache ? icache_mode_o[2*c+:2] :
                sel == e_reg_dcache ? dcache_mode_o[2*c+:2] :
                sel == e_reg_cce    ? {1'b0, cce_mode_o[c]} :
                                      {core_frozen_i[c], freeze_o[c]};
  end
`else
  assign err   = bad_core || bad_sel || !cfg_w_i || sel == e_reg_status;
  assign rdata = 2'd0;
`endif
  for (genvar c = 0; c < num_core_p; c++) begin : g_core
    bp_cfg_core_regs u_regs (
      .clk         (clk_i),
      .rst         (reset_i),
      .we          (core_we[c]),
      .sel         (sel),
      .data        (cfg_data_i[1:0]),
      .freeze      (freeze_o[c]),
      .icache_mode (icache_mode_o[2*c+:2]),
      .dcache_mode (dcache_mode_o[2*c+:2]),
      .cce_mode    (cce_mode_o[c])
    );
  end
  // A freeze raise waits for every targeted core to quiesce or for the timeout.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= e_ready;
      cfg_ready_o <= 1'b0;
      resp_v_o    <= 1'b0;
      resp_err_o  <= 1'b0;
      resp_data_o <= '0;
      cnt         <= '0;
      wait_mask   <= '0;
    end else begin
      case (state)
        e_ready: begin
          cfg_ready_o <= !accept;
          if (accept) begin
            resp_data_o <= (cfg_w_i || err) ? '0 : data_width_p'(rdata);
            resp_err_o  <= err;
            wait_mask   <= target;
            cnt         <= '0;
            state       <= (!err && freeze_up) ? e_wait : e_resp;
            resp_v_o    <= err || !freeze_up;
          end
        end
        e_wait: begin
          cnt <= cnt + 1'b1;
          if (&(core_frozen_i | ~wait_mask) || int'(cnt) + 1 >= freeze_timeout_p) begin
            resp_err_o <= !(&(core_frozen_i | ~wait_mask));
            resp_v_o   <= 1'b1;
            state      <= e_resp;
          end
        end
        e_resp: begin
          if (resp_yumi_i) begin
            resp_v_o    <= 1'b0;
            cfg_ready_o <= 1'b1;
            state       <= e_ready;
          end
        end
        default: state <= e_ready;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_cfg_regfile.sv
// tb_bp_cfg_regfile: scoreboard bench for bp_cfg_regfile (4 cores, freeze timeout 8).
module tb_bp_cfg_regfile;
  logic clk = 0, reset_i = 1, cfg_v = 0, cfg_w = 0, resp_yumi = 0;
  logic [7:0] cfg_addr = 0;
  logic [63:0] cfg_data = 0;
  logic cfg_ready_o, resp_v_o, resp_err_o;
  logic [63:0] resp_data_o;
  logic [3:0] core_frozen = 4'hF, freeze_o, cce_mode_o;
  logic [7:0] icache_mode_o, dcache_mode_o;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {string name; logic [63:0] data; logic err; int due;} exp_t;
  exp_t sb[$];
  bp_cfg_regfile #(.num_core_p(4), .data_width_p(64), .addr_width_p(8), .freeze_timeout_p(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .cfg_v_i(cfg_v), .cfg_w_i(cfg_w), .cfg_addr_i(cfg_addr),
    .cfg_data_i(cfg_data), .cfg_ready_o(cfg_ready_o), .resp_v_o(resp_v_o), .resp_data_o(resp_data_o),
    .resp_err_o(resp_err_o), .resp_yumi_i(resp_yumi), .core_frozen_i(core_frozen), .freeze_o(freeze_o),
    .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Monitor: pops one expectation per response, checks content and arrival cycle.
  always @(negedge clk) begin
    exp_t e;
    resp_yumi = 0;
    if (!reset_i && resp_v_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_resp got data=%h err=%b at cycle %0d, want no response", resp_data_o, resp_err_o, cyc);
      end else begin
        e = sb.pop_front();
        if (resp_data_o !== e.data || resp_err_o !== e.err || cyc != e.due) begin
          errors++;
          $display("FAIL %s got data=%h err=%b cycle=%0d want data=%h err=%b cycle=%0d",
                   e.name, resp_data_o, resp_err_o, cyc, e.data, e.err, e.due);
        end
      end
      resp_yumi = 1;
    end
  end
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic issue(input string name, input logic w, input logic [7:0] addr, input logic [63:0] data,
                       input logic [63:0] exp_data, input logic exp_err, input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!cfg_ready_o && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (!cfg_ready_o) begin
      errors++;
      $display("FAIL %s_ready got 0 want 1", name);
    end else begin
      cfg_v = 1; cfg_w = w; cfg_addr = addr; cfg_data = data;
      if (push) sb.push_back('{name, exp_data, exp_err, cyc + lat});
      @(posedge clk);
      #1 cfg_v = 0;
    end
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending responses want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_freeze", 64'(freeze_o), 64'hF);
    chk("rst_icache", 64'(icache_mode_o), 64'h0);
    chk("rst_dcache", 64'(dcache_mode_o), 64'h0);
    chk("rst_cce", 64'(cce_mode_o), 64'h0);
    chk("rst_ready", 64'(cfg_ready_o), 64'h0);
    chk("rst_resp_v", 64'(resp_v_o), 64'h0);
    reset_i = 0;
    @(negedge clk);
    chk("ready_rise", 64'(cfg_ready_o), 64'h1);
    issue("icache_wr", 1, 8'h21, 64'h1, 64'h0, 0, 1, 1);
    drain();
    chk("icache_val", 64'(icache_mode_o), 64'h10);
    issue("unfreeze1", 1, 8'h10, 64'h0, 64'h0, 0, 1, 1);
    drain();
    chk("unfreeze1_val", 64'(freeze_o), 64'hD);
    core_frozen[1] = 0;
    issue("freeze1_ack", 1, 8'h10, 64'h1, 64'h0, 0, 6, 1);
    repeat (4) @(posedge clk);
    #1 core_frozen[1] = 1;
    drain();
    chk("freeze1_val", 64'(freeze_o), 64'hF);
    issue("unfreeze1b", 1, 8'h10, 64'h0, 64'h0, 0, 1, 1);
    drain();
    core_frozen[1] = 0;
    issue("freeze1_tmo", 1, 8'h10, 64'h1, 64'h0, 1, 9, 1);
    drain();
    chk("tmo_freeze", 64'(freeze_o[1]), 64'h1);
    issue("freeze_same", 1, 8'h10, 64'h1, 64'h0, 0, 1, 1);
    issue("bcast_cce", 1, 8'hF3, 64'h1, 64'h0, 0, 1, 1);
    drain();
    chk("bcast_cce_val", 64'(cce_mode_o), 64'hF);
    issue("bcast_rd", 0, 8'hF0, 64'h0, 64'h0, 1, 1, 1);
    issue("bad_core_rd", 0, 8'h50, 64'h0, 64'h0, 1, 1, 1);
    issue("bad_core_wr", 1, 8'h53, 64'h0, 64'h0, 1, 1, 1);
    issue("ro_wr", 1, 8'h04, 64'h1, 64'h0, 1, 1, 1);
    issue("bad_sel_wr", 1, 8'h07, 64'h1, 64'h0, 1, 1, 1);
    drain();
    chk("err_no_change_cce", 64'(cce_mode_o), 64'hF);
    chk("err_no_change_frz", 64'(freeze_o), 64'hF);
`ifdef BP_CFG_READBACK_EN
    issue("rd_icache", 0, 8'h21, 64'h0, 64'h1, 0, 1, 1);
    issue("rd_status1", 0, 8'h14, 64'h0, 64'h1, 0, 1, 1);
`else
    issue("rd_icache", 0, 8'h21, 64'h0, 64'h0, 1, 1, 1);
    issue("rd_status1", 0, 8'h14, 64'h0, 64'h0, 1, 1, 1);
`endif
    issue("unfreeze2", 1, 8'h20, 64'h0, 64'h0, 0, 1, 1);
    drain();
    core_frozen[2] = 0;
    issue("rst_wait", 1, 8'h20, 64'h1, 64'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset_i = 1;
    @(negedge clk);
    chk("abort_freeze", 64'(freeze_o), 64'hF);
    chk("abort_icache", 64'(icache_mode_o), 64'h0);
    chk("abort_cce", 64'(cce_mode_o), 64'h0);
    chk("abort_resp_v", 64'(resp_v_o), 64'h0);
    chk("abort_ready", 64'(cfg_ready_o), 64'h0);
    core_frozen = 4'hF;
    reset_i = 0;
    @(negedge clk);
    chk("abort_ready_rise", 64'(cfg_ready_o), 64'h1);
    repeat (12) @(negedge clk);
    chk("abort_no_resp", 64'(sb.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
